// File: rtl/pulse_proximity_meter_if.sv
// Pulse proximity meter bus: control/config in, graded result out.
// master drives configuration and the pulse pin, slave is the meter.
interface pulse_proximity_meter_if #(
  parameter int CNT_W = 16,
  parameter int SEL_W = 3,
  parameter int TOL_W = 8
);
  logic             enable;
  logic             pulse_in;
  logic [SEL_W-1:0] gate_sel;
  logic [CNT_W-1:0] target;
  logic [TOL_W-1:0] tol_fine;
  logic [TOL_W-1:0] tol_coarse;
  logic [CNT_W-1:0] count_out;
  logic             result_vld;
  logic             in_tune;
  logic             near;
  logic             far;
  logic             dir_high;
  logic             overflow;

  modport master (
    output enable, pulse_in, gate_sel, target,
    output tol_fine, tol_coarse,
    input  count_out, result_vld, in_tune,
    input  near, far, dir_high, overflow
  );

  modport slave (
    input  enable, pulse_in, gate_sel, target,
    input  tol_fine, tol_coarse,
    output count_out, result_vld, in_tune,
    output near, far, dir_high, overflow
  );
endinterface

// File: rtl/pulse_proximity_meter.sv
// Counts pulse edges over a 2^n-cycle gate window and grades
// the count against a target with fine/coarse tolerance bands.
module pulse_proximity_meter #(
  parameter int CNT_W     = 16,
  parameter int BASE_LOG2 = 10,
  parameter int SEL_W     = 3,
  parameter int TOL_W     = 8
) (
  input logic clk,
  input logic rst,
  pulse_proximity_meter_if.slave bus
);
  localparam int GW  = BASE_LOG2 + (1 << SEL_W) - 1;
  localparam int GW1 = GW + 1;
  localparam int DW  = CNT_W + 1;
  localparam int CW  = (DW > TOL_W) ? DW : TOL_W;

  typedef enum logic [1:0] {
    IDLE, LOAD, GATE, REPORT
  } state_t;

  state_t           state_q;
  logic [2:0]       sync_q;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] tgt_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [GW-1:0]    gcnt_q;
  logic [CNT_W-1:0] count_q;
  logic             vld_q, tune_q, near_q;
  logic             far_q, dir_q, ovfo_q;

  logic            edge_w;
  logic [GW1-1:0]  win_w;
  logic            gate_done_w;
  logic [DW-1:0]   diff_w, mag_w;
  logic [CW-1:0]   mag_x, fine_x, coarse_x;
  logic            tune_w, near_w, far_w, dir_w;

  assign edge_w = sync_q[1] & ~sync_q[2];
  assign win_w  = GW1'(1) << (BASE_LOG2 + int'(sel_q));
  assign gate_done_w =
    (({1'b0, gcnt_q} + GW1'(1)) == win_w);

  assign diff_w   = {1'b0, cnt_q} - {1'b0, tgt_q};
  assign mag_w    = diff_w[DW-1] ? (~diff_w + DW'(1))
                                 : diff_w;
  assign mag_x    = CW'(mag_w);
  assign fine_x   = CW'(bus.tol_fine);
  assign coarse_x = CW'(bus.tol_coarse);

  // two-flop synchroniser plus edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], bus.pulse_in};
  end

  // saturating edge counter, overflow sticks for the window
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (edge_w) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // band grading, fine band checked first, overflow forces far
  always_comb begin
    tune_w = 1'b0;
    near_w = 1'b0;
    far_w  = 1'b0;
    dir_w  = (cnt_q > tgt_q);
    if (ovf_q) begin
      far_w = 1'b1;
      dir_w = 1'b1;
    end else if (mag_x <= fine_x) begin
      tune_w = 1'b1;
    end else if (mag_x <= coarse_x) begin
      near_w = 1'b1;
    end else begin
      far_w = 1'b1;
    end
  end

  // window sequencer with registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      gcnt_q  <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
      tune_q  <= 1'b0;
      near_q  <= 1'b0;
      far_q   <= 1'b0;
      dir_q   <= 1'b0;
      ovfo_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.enable) state_q <= LOAD;
        end
        LOAD: begin
          if (!bus.enable) begin
            state_q <= IDLE;
          end else begin
            sel_q   <= bus.gate_sel;
            tgt_q   <= bus.target;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            gcnt_q  <= '0;
            state_q <= GATE;
          end
        end
        GATE: begin
          if (!bus.enable) begin
            state_q <= IDLE;
          end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            gcnt_q <= gcnt_q + GW'(1);
            if (gate_done_w) state_q <= REPORT;
          end
        end
        REPORT: begin
          count_q <= cnt_q;
          vld_q   <= 1'b1;
          tune_q  <= tune_w;
          near_q  <= near_w;
          far_q   <= far_w;
          dir_q   <= dir_w;
          ovfo_q  <= ovf_q;
          state_q <= bus.enable ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.count_out  = count_q;
  assign bus.result_vld = vld_q;
  assign bus.in_tune    = tune_q;
  assign bus.near       = near_q;
  assign bus.far        = far_q;
  assign bus.dir_high   = dir_q;
  assign bus.overflow   = ovfo_q;
endmodule

// File: tb/tb_pulse_proximity_meter.sv
// Bench for pulse_proximity_meter: window-level model plus
// directed scenarios on an 8-bit and a 4-bit counter instance.
module tb_pulse_proximity_meter;
  logic clk = 1'b0;
  logic rst;
  logic pin;
  int   period = 0;
  int   ph = 0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pulse_proximity_meter_if #(.CNT_W(8), .SEL_W(2),
    .TOL_W(8)) bus8 ();
  pulse_proximity_meter_if #(.CNT_W(4), .SEL_W(2),
    .TOL_W(8)) bus4 ();

  pulse_proximity_meter #(.CNT_W(8), .BASE_LOG2(4),
    .SEL_W(2), .TOL_W(8)) u8 (
    .clk(clk), .rst(rst), .bus(bus8.slave));

  pulse_proximity_meter #(.CNT_W(4), .BASE_LOG2(4),
    .SEL_W(2), .TOL_W(8)) u4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  assign bus8.pulse_in   = pin;
  assign bus4.pulse_in   = pin;
  assign bus4.enable     = bus8.enable;
  assign bus4.gate_sel   = bus8.gate_sel;
  assign bus4.target     = bus8.target[3:0];
  assign bus4.tol_fine   = bus8.tol_fine;
  assign bus4.tol_coarse = bus8.tol_coarse;

  // square-wave pulse source, high for the first half period
  always @(posedge clk) begin
    #2;
    if (period == 0) begin
      pin = 1'b0;
    end else begin
      pin = (ph < period / 2);
      ph = (ph + 1) % period;
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0d want %0d",
               nm, cyc, act, exp);
    end
  endtask

  // window-level model: pin history, window spans, graded sums
  bit hist [0:4095];
  bit m_act = 1'b0;
  int m_L = 0, m_W = 0, m_tgt = 0;
  int e_cnt = 0, e_vld = 0, e_tune = 0, e_near = 0;
  int e_far = 0, e_dir = 0, e_ovf = 0;

  function automatic int edge_at(input int k);
    if (k < 3 || k > 4095) return 0;
    return (hist[k-2] && !hist[k-3]) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int n, mag;
    cyc++;
    if (cyc < 4096) hist[cyc] = rst ? 1'b0 : pin;
    e_vld = 0;
    if (rst) begin
      m_act = 1'b0;
      e_cnt = 0; e_tune = 0; e_near = 0;
      e_far = 0; e_dir = 0; e_ovf = 0;
    end else if (!m_act) begin
      if (bus8.enable) begin
        m_act = 1'b1;
        m_L = cyc + 1;
      end
    end else if (cyc == m_L) begin
      if (!bus8.enable) begin
        m_act = 1'b0;
      end else begin
        m_W = 16 << bus8.gate_sel;
        m_tgt = int'(bus8.target);
      end
    end else if (cyc <= m_L + m_W) begin
      if (!bus8.enable) m_act = 1'b0;
    end else begin
      n = 0;
      for (int k = m_L + 1; k <= m_L + m_W; k++)
        n += edge_at(k);
      e_ovf = (n > 255) ? 1 : 0;
      e_cnt = e_ovf ? 255 : n;
      mag = (e_cnt > m_tgt) ? e_cnt - m_tgt
                            : m_tgt - e_cnt;
      e_dir = (e_ovf || e_cnt > m_tgt) ? 1 : 0;
      e_tune = 0; e_near = 0; e_far = 0;
      if (e_ovf) e_far = 1;
      else if (mag <= int'(bus8.tol_fine)) e_tune = 1;
      else if (mag <= int'(bus8.tol_coarse)) e_near = 1;
      else e_far = 1;
      e_vld = 1;
      if (bus8.enable) m_L = cyc + 1;
      else m_act = 1'b0;
    end
  end

  // every-cycle comparison of the 8-bit instance vs model
  always @(posedge clk) begin
    #1;
    chk("m_count", int'(bus8.count_out), e_cnt);
    chk("m_vld", int'(bus8.result_vld), e_vld);
    chk("m_tune", int'(bus8.in_tune), e_tune);
    chk("m_near", int'(bus8.near), e_near);
    chk("m_far", int'(bus8.far), e_far);
    chk("m_dir", int'(bus8.dir_high), e_dir);
    chk("m_ovf", int'(bus8.overflow), e_ovf);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_strobe(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (bus8.result_vld) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      nchk++;
      nerr++;
      $display("FAIL strobe_timeout at cycle %0d: got none want 1",
               cyc);
    end
  endtask

  task automatic set_period(input int p);
    period = p;
    ph = 0;
  endtask

  task automatic chk_res(input string nm, input int c,
                         input int t, input int n, input int f,
                         input int d, input int o);
    chk({nm, "_count"}, int'(bus8.count_out), c);
    chk({nm, "_tune"}, int'(bus8.in_tune), t);
    chk({nm, "_near"}, int'(bus8.near), n);
    chk({nm, "_far"}, int'(bus8.far), f);
    chk({nm, "_dir"}, int'(bus8.dir_high), d);
    chk({nm, "_ovf"}, int'(bus8.overflow), o);
  endtask

  task automatic chk_zero(input string nm);
    chk_res(nm, 0, 0, 0, 0, 0, 0);
    chk({nm, "_vld"}, int'(bus8.result_vld), 0);
    chk({nm, "_c4"}, int'(bus4.count_out), 0);
    chk({nm, "_o4"}, int'(bus4.overflow), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d: got hang want finish",
             cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10;
    int ns;
    rst = 1'b1;
    bus8.enable = 1'b0;
    bus8.gate_sel = '0;
    bus8.target = '0;
    bus8.tol_fine = '0;
    bus8.tol_coarse = '0;
    cycles(3);
    chk_zero("reset");
    rst = 1'b0;
    cycles(2);

    // 16-cycle window, period 4, target 4: in tune
    bus8.gate_sel = 2'd0;
    bus8.target = 8'd4;
    bus8.tol_fine = 8'd0;
    bus8.tol_coarse = 8'd2;
    set_period(4);
    bus8.enable = 1'b1;
    wait_strobe(100, s0);
    chk_res("s1", 4, 1, 0, 0, 0, 0);

    // gate_sel change mid-window only hits the next window
    cycles(3);
    bus8.gate_sel = 2'd1;
    wait_strobe(100, s1);
    chk("s6_gap16", s1 - s0, 18);
    chk_res("s6a", 4, 1, 0, 0, 0, 0);
    wait_strobe(100, s2);
    chk("s6_gap32", s2 - s1, 34);
    chk_res("s2", 8, 0, 0, 1, 1, 0);

    // period 2, target 10, tol 1/3: near, below target
    cycles(3);
    bus8.gate_sel = 2'd0;
    bus8.target = 8'd10;
    bus8.tol_fine = 8'd1;
    bus8.tol_coarse = 8'd3;
    set_period(2);
    wait_strobe(100, s3);
    wait_strobe(100, s4);
    chk("s3_gap", s4 - s3, 18);
    chk_res("s3", 8, 0, 1, 0, 0, 0);

    // 128-cycle window: 4-bit instance saturates
    cycles(3);
    bus8.gate_sel = 2'd3;
    bus8.target = 8'd4;
    wait_strobe(100, s5);
    wait_strobe(200, s6);
    chk("s4_gap", s6 - s5, 130);
    chk_res("s4_8b", 64, 0, 0, 1, 1, 0);
    chk("s4_vld4", int'(bus4.result_vld), 1);
    chk("s4_count4", int'(bus4.count_out), 15);
    chk("s4_ovf4", int'(bus4.overflow), 1);
    chk("s4_far4", int'(bus4.far), 1);
    chk("s4_near4", int'(bus4.near), 0);
    chk("s4_tune4", int'(bus4.in_tune), 0);
    chk("s4_dir4", int'(bus4.dir_high), 1);

    // back to scenario 1 settings, then abort mid-GATE
    cycles(3);
    bus8.gate_sel = 2'd0;
    bus8.tol_fine = 8'd0;
    bus8.tol_coarse = 8'd2;
    set_period(4);
    wait_strobe(200, s7);
    wait_strobe(100, s8);
    chk_res("s5pre", 4, 1, 0, 0, 0, 0);
    cycles(5);
    bus8.enable = 1'b0;
    ns = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (bus8.result_vld) ns++;
    end
    chk("s5_abort_strobes", ns, 0);
    chk_res("s5_hold", 4, 1, 0, 0, 0, 0);
    @(negedge clk);
    bus8.enable = 1'b1;
    wait_strobe(100, s9);
    chk_res("s5_resume", 4, 1, 0, 0, 0, 0);

    // reset mid-GATE clears outputs immediately
    cycles(6);
    rst = 1'b1;
    bus8.enable = 1'b0;
    set_period(0);
    #1;
    chk_zero("s5_rst");
    cycles(3);
    rst = 1'b0;
    cycles(3);
    set_period(4);
    bus8.enable = 1'b1;
    wait_strobe(100, s10);
    chk_res("s5_after_rst", 4, 1, 0, 0, 0, 0);
    cycles(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
